// File: rtl/bcd_seg_display.sv
// bcd_seg_display
//   Multi-digit decimal driver for the 7-segment front panel. A WIDTH-bit
//   value (two's complement when SIGNED=1) is accepted via valid/ready,
//   converted to BCD by a double-dabble engine running one bit per clock,
//   and presented as registered active-low segment bytes {a,b,c,d,e,f,g,dp}.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   in_data is valid
//   in_ready  out  block can accept a value (high only in IDLE)
//   in_data   in   WIDTH-bit value to display
//   out_valid out  one-cycle pulse when segs/sign_seg/ovf update
//   segs      out  DIGITS segment bytes, byte k = digit k (k=0 least significant)
//   sign_seg  out  sign digit (minus or blank)
//   ovf       out  value did not fit in DIGITS digits ("E" shown on digit 0)
module bcd_seg_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int SIGNED = 1,
    parameter int LZB    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    output logic [8*DIGITS-1:0]   segs,
    output logic [7:0]            sign_seg,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CONV = 2'd1;
    localparam logic [1:0] FMT  = 2'd2;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hFD;
    localparam logic [7:0] SEG_E     = 8'h61;

    logic [1:0]            state;
    logic [WIDTH-1:0]      mag;
    logic [4*DIGITS-1:0]   bcd;
    logic [4*DIGITS-1:0]   bcd_adj;
    logic [CW-1:0]         cnt;
    logic                  neg;
    logic                  ovf_acc;
    logic                  neg_in;
    logic [8*DIGITS-1:0]   segs_fmt;
    logic [7:0]            sign_fmt;
    logic                  leading;

    function automatic logic [7:0] glyph(input logic [3:0] d);
        case (d)
            4'd0:    glyph = 8'b0000_0011;
            4'd1:    glyph = 8'b1001_1111;
            4'd2:    glyph = 8'b0010_0101;
            4'd3:    glyph = 8'b0000_1101;
            4'd4:    glyph = 8'b1001_1001;
            4'd5:    glyph = 8'b0100_1001;
            4'd6:    glyph = 8'b0100_0001;
            4'd7:    glyph = 8'b0001_1111;
            4'd8:    glyph = 8'b0000_0001;
            4'd9:    glyph = 8'b0000_1001;
            default: glyph = SEG_BLANK;
        endcase
    endfunction

    assign in_ready = (state == IDLE);
    assign neg_in   = (SIGNED != 0) && in_data[WIDTH-1];

    // Double-dabble pre-shift correction: any digit >= 5 would exceed 9
    // after doubling, so add 3 to make it carry into the next digit.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (bcd[4*k +: 4] >= 4'd5)
                bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
        end
    end

    // Output formatting. Scans from the top digit down; while 'leading' is
    // set, zero digits stay blank. Digit 0 always shows.
    always_comb begin
        segs_fmt = '1;
        sign_fmt = SEG_BLANK;
        leading  = (LZB != 0);
        if (ovf_acc) begin
            segs_fmt[7:0] = SEG_E;
        end else begin
            if (neg)
                sign_fmt = SEG_MINUS;
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (leading && (DIGITS - 1 - i) != 0 &&
                    bcd[4*(DIGITS-1-i) +: 4] == 4'd0) begin
                    segs_fmt[8*(DIGITS-1-i) +: 8] = SEG_BLANK;
                end else begin
                    leading = 1'b0;
                    segs_fmt[8*(DIGITS-1-i) +: 8] = glyph(bcd[4*(DIGITS-1-i) +: 4]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mag       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            neg       <= 1'b0;
            ovf_acc   <= 1'b0;
            segs      <= '1;
            sign_seg  <= '1;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Two's-complement negate in WIDTH bits; the most
                        // negative value maps to 2^(WIDTH-1) as unsigned.
                        mag     <= neg_in ? (~in_data + WIDTH'(1)) : in_data;
                        neg     <= neg_in;
                        bcd     <= '0;
                        ovf_acc <= 1'b0;
                        cnt     <= CW'(WIDTH);
                        state   <= CONV;
                    end
                end
                CONV: begin
                    {bcd, mag} <= {bcd_adj[4*DIGITS-2:0], mag, 1'b0};
                    // A 1 leaving the top BCD bit means the value needs
                    // more than DIGITS digits; remember it for FMT.
                    if (bcd_adj[4*DIGITS-1])
                        ovf_acc <= 1'b1;
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1))
                        state <= FMT;
                end
                FMT: begin
                    segs      <= segs_fmt;
                    sign_seg  <= sign_fmt;
                    ovf       <= ovf_acc;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seg_display.sv
// tb_bcd_seg_display
//   Four instances (default, LZB=0, DIGITS=2, SIGNED=0) share the same
//   stimulus. A cycle-level behavioural model predicts every output on every
//   cycle; directed cases add literal expectations.
module tb_bcd_seg_display;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;

    logic        in_ready_a, out_valid_a, ovf_a;
    logic [23:0] segs_a;
    logic [7:0]  sign_a;
    logic        in_ready_n, out_valid_n, ovf_n;
    logic [23:0] segs_n;
    logic [7:0]  sign_n;
    logic        in_ready_d, out_valid_d, ovf_d;
    logic [15:0] segs_d;
    logic [7:0]  sign_d;
    logic        in_ready_u, out_valid_u, ovf_u;
    logic [23:0] segs_u;
    logic [7:0]  sign_u;

    bcd_seg_display #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .LZB(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .out_valid(out_valid_a), .segs(segs_a),
        .sign_seg(sign_a), .ovf(ovf_a));

    bcd_seg_display #(.WIDTH(8), .DIGITS(3), .SIGNED(1), .LZB(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_n),
        .in_data(in_data), .out_valid(out_valid_n), .segs(segs_n),
        .sign_seg(sign_n), .ovf(ovf_n));

    bcd_seg_display #(.WIDTH(8), .DIGITS(2), .SIGNED(1), .LZB(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_d),
        .in_data(in_data), .out_valid(out_valid_d), .segs(segs_d),
        .sign_seg(sign_d), .ovf(ovf_d));

    bcd_seg_display #(.WIDTH(8), .DIGITS(3), .SIGNED(0), .LZB(1)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .out_valid(out_valid_u), .segs(segs_u),
        .sign_seg(sign_u), .ovf(ovf_u));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] glyph_t [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                                 8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

    int pd [4] = '{3, 3, 2, 3};
    bit pl [4] = '{1, 0, 1, 1};
    bit ps [4] = '{1, 1, 1, 0};

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Display rules in plain arithmetic: signed value, magnitude, decimal
    // digits by division, blanking by comparing against powers of ten.
    function automatic void model(input logic [7:0] v, input int digits, input bit sgn,
                                  input bit lzb, output logic [23:0] s,
                                  output logic [7:0] sg, output logic o);
        int val, mag, p;
        val = int'(v);
        if (sgn && v[7]) val = val - 256;
        mag = (val < 0) ? -val : val;
        p = 1;
        for (int k = 0; k < digits; k++) p = p * 10;
        s  = '1;
        sg = 8'hFF;
        o  = 1'b0;
        if (mag >= p) begin
            o = 1'b1;
            s[7:0] = 8'h61;
        end else begin
            if (val < 0) sg = 8'hFD;
            p = 1;
            for (int k = 0; k < digits; k++) begin
                if (!(lzb && k > 0 && mag < p))
                    s[8*k +: 8] = glyph_t[(mag / p) % 10];
                p = p * 10;
            end
        end
    endfunction

    task automatic pin(input string name, input logic [7:0] v, input int digits, input bit sgn,
                       input bit lzb, input logic [23:0] es, input logic [7:0] eg, input logic eo);
        logic [23:0] s;
        logic [7:0]  g;
        logic        o;
        model(v, digits, sgn, lzb, s, g, o);
        chk(name, {s, g, o}, {es, eg, eo});
    endtask

    // Cycle-level expectation state
    logic [23:0] e_s [4];
    logic [7:0]  e_g [4];
    logic        e_o [4];
    logic        e_v;
    int          busy;
    logic [7:0]  pend;

    initial begin
        busy = 0;
        e_v  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e_s[i] = '1; e_g[i] = 8'hFF; e_o[i] = 1'b0;
        end
    end

    // Compare on the falling edge, then advance the model across the next
    // rising edge using the inputs already applied for it.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 0;
            e_v  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                e_s[i] = '1; e_g[i] = 8'hFF; e_o[i] = 1'b0;
            end
        end
        chk("cyc_a", {segs_a, sign_a, ovf_a, out_valid_a, in_ready_a},
            {e_s[0], e_g[0], e_o[0], e_v, busy == 0});
        chk("cyc_n", {segs_n, sign_n, ovf_n, out_valid_n, in_ready_n},
            {e_s[1], e_g[1], e_o[1], e_v, busy == 0});
        chk("cyc_d", {segs_d, sign_d, ovf_d, out_valid_d, in_ready_d},
            {e_s[2][15:0], e_g[2], e_o[2], e_v, busy == 0});
        chk("cyc_u", {segs_u, sign_u, ovf_u, out_valid_u, in_ready_u},
            {e_s[3], e_g[3], e_o[3], e_v, busy == 0});
        if (rst_n) begin
            e_v = 1'b0;
            if (busy == 0) begin
                if (in_valid) begin
                    busy = 9;
                    pend = in_data;
                end
            end else begin
                busy--;
                if (busy == 0) begin
                    for (int i = 0; i < 4; i++)
                        model(pend, pd[i], ps[i], pl[i], e_s[i], e_g[i], e_o[i]);
                    e_v = 1'b1;
                end
            end
        end
    end

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready_a;
        end
        chk("idle_reached", ok, 1'b1);
    endtask

    task automatic wait_out(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid_a;
        end
        chk({name, "_pulse"}, seen, 1'b1);
    endtask

    task automatic send(input logic [7:0] v);
        wait_idle();
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = v;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_data = 8'($urandom);
    endtask

    logic [7:0] corner [8] = '{8'h00, 8'h7F, 8'h80, 8'hFF, 8'h64, 8'h63, 8'h9C, 8'h09};

    initial begin
        // Model pins: hand-derived panel contents
        pin("pin_123",   8'h7B, 3, 1, 1, 24'h9F250D, 8'hFF, 1'b0);
        pin("pin_m10",   8'hF6, 3, 1, 1, 24'hFF9F03, 8'hFD, 1'b0);
        pin("pin_m128",  8'h80, 3, 1, 1, 24'h9F2501, 8'hFD, 1'b0);
        pin("pin_0lzb",  8'h00, 3, 1, 1, 24'hFFFF03, 8'hFF, 1'b0);
        pin("pin_0nolz", 8'h00, 3, 1, 0, 24'h030303, 8'hFF, 1'b0);
        pin("pin_ovf",   8'h64, 2, 1, 1, 24'hFFFF61, 8'hFF, 1'b1);
        pin("pin_u255",  8'hFF, 3, 0, 1, 24'h254949, 8'hFF, 1'b0);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(8'h7B); wait_out("d123");
        chk("dir_123", {segs_a, sign_a, ovf_a}, {24'h9F250D, 8'hFF, 1'b0});
        send(8'hF6); wait_out("dm10");
        chk("dir_m10", {segs_a, sign_a, ovf_a}, {24'hFF9F03, 8'hFD, 1'b0});
        send(8'h80); wait_out("dm128");
        chk("dir_m128", {segs_a, sign_a, ovf_a}, {24'h9F2501, 8'hFD, 1'b0});
        send(8'h00); wait_out("d0");
        chk("dir_0lzb", {segs_a, sign_a, ovf_a}, {24'hFFFF03, 8'hFF, 1'b0});
        chk("dir_0nolz", {segs_n, sign_n, ovf_n}, {24'h030303, 8'hFF, 1'b0});
        send(8'h64); wait_out("d100");
        chk("dir_ovf", {segs_d, sign_d, ovf_d}, {16'hFF61, 8'hFF, 1'b1});
        chk("dir_100", {segs_a, sign_a, ovf_a}, {24'h9F0303, 8'hFF, 1'b0});
        send(8'hFF); wait_out("dff");
        chk("dir_u255", {segs_u, sign_u, ovf_u}, {24'h254949, 8'hFF, 1'b0});
        chk("dir_m1", {segs_a, sign_a, ovf_a}, {24'hFFFF9F, 8'hFD, 1'b0});

        // in_valid held high with data changing during the conversion
        wait_idle();
        @(posedge clk);
        #1 in_valid = 1'b1;
        in_data = 8'h2A;
        repeat (8) begin
            @(posedge clk);
            #1 in_data = 8'($urandom);
        end
        wait_out("dhold");
        chk("dir_hold42", {segs_a, sign_a, ovf_a}, {24'hFF9925, 8'hFF, 1'b0});
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b_accept", in_ready_a, 1'b0);

        // Reset in the middle of a conversion
        send(8'h55);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 chk("rst_async", {segs_a, sign_a, ovf_a, out_valid_a, in_ready_a},
               {24'hFFFFFF, 8'hFF, 1'b0, 1'b0, 1'b1});
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized traffic, biased toward the interesting values
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1 in_valid = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0)
                in_data = corner[$urandom_range(0, 7)];
            else
                in_data = 8'($urandom);
        end
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
